// File: rtl/cnn_layer_sequencer.sv
// rtl/cnn_layer_sequencer.sv - conv/pool layer sequencer with pool bypass, watchdog, abort and busy-cycle count
module cnn_layer_sequencer #(
  parameter int                    NUM_LAYERS     = 2,
  parameter int                    IDX_W          = 2,
  parameter logic [NUM_LAYERS-1:0] POOL_EN        = {NUM_LAYERS{1'b1}},
  parameter int                    TIMEOUT_W      = 16,
  parameter int                    TIMEOUT_CYCLES = 16'hFFFF,
  parameter int                    CYC_W          = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  conv_start,
  input  logic                  conv_done,
  output logic                  pool_start,
  input  logic                  pool_done,
  output logic [IDX_W-1:0]      layer_idx,
  output logic [NUM_LAYERS-1:0] conv_done_vec,
  output logic [NUM_LAYERS-1:0] pool_done_vec,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [IDX_W-1:0]      err_layer,
  output logic [CYC_W-1:0]      cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_CONV_GO, S_CONV_WAIT, S_POOL_GO, S_POOL_WAIT, S_NEXT, S_FINISH, S_ERROR
  } state_t;

  localparam logic [TIMEOUT_W-1:0] WD_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_LAYERS - 1);

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      layer_idx_q, layer_idx_d;
  logic [NUM_LAYERS-1:0] conv_vec_q, conv_vec_d;
  logic [NUM_LAYERS-1:0] pool_vec_q, pool_vec_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [IDX_W-1:0]      err_layer_q, err_layer_d;
  logic [CYC_W-1:0]      cycle_count_q, cycle_count_d;
  logic [TIMEOUT_W-1:0]  wd_q, wd_d;

  logic [NUM_LAYERS-1:0] cur_sel;
  logic                  pool_en_cur;
  logic                  busy_w;
  logic                  wd_expired;

  // One-hot of the current layer; avoids indexing a NUM_LAYERS vector with a wider index.
  always_comb begin
    cur_sel = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      cur_sel[i] = (layer_idx_q == IDX_W'(i));
    end
  end

  assign pool_en_cur = |(POOL_EN & cur_sel);
  assign busy_w      = (state_q != S_IDLE) && (state_q != S_ERROR);
  assign wd_expired  = (wd_q == WD_LIMIT);

  always_comb begin
    state_d       = state_q;
    layer_idx_d   = layer_idx_q;
    conv_vec_d    = conv_vec_q;
    pool_vec_d    = pool_vec_q;
    done_d        = done_q;
    error_d       = error_q;
    err_layer_d   = err_layer_q;
    cycle_count_d = cycle_count_q;
    wd_d          = '0;

    if (busy_w && (cycle_count_q != {CYC_W{1'b1}})) begin
      cycle_count_d = cycle_count_q + 1'b1;
    end

    if (busy_w && abort) begin
      state_d = S_ERROR;
    end else begin
      case (state_q)
        S_IDLE, S_ERROR: begin
          if (start) begin
            done_d        = 1'b0;
            error_d       = 1'b0;
            err_layer_d   = '0;
            conv_vec_d    = '0;
            pool_vec_d    = '0;
            cycle_count_d = '0;
            layer_idx_d   = '0;
            state_d       = S_CONV_GO;
          end
        end
        S_CONV_GO: state_d = S_CONV_WAIT;
        S_CONV_WAIT: begin
          wd_d = wd_q + 1'b1;
          if (conv_done) begin
            conv_vec_d = conv_vec_q | cur_sel;
            state_d    = pool_en_cur ? S_POOL_GO : S_NEXT;
          end else if (wd_expired) begin
            state_d = S_ERROR;
          end
        end
        S_POOL_GO: state_d = S_POOL_WAIT;
        S_POOL_WAIT: begin
          wd_d = wd_q + 1'b1;
          if (pool_done) begin
            pool_vec_d = pool_vec_q | cur_sel;
            state_d    = S_NEXT;
          end else if (wd_expired) begin
            state_d = S_ERROR;
          end
        end
        S_NEXT: begin
          if (layer_idx_q == LAST_IDX) begin
            state_d = S_FINISH;
          end else begin
            layer_idx_d = layer_idx_q + 1'b1;
            state_d     = S_CONV_GO;
          end
        end
        S_FINISH: begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if ((state_d == S_ERROR) && (state_q != S_ERROR)) begin
      error_d     = 1'b1;
      err_layer_d = layer_idx_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      layer_idx_q   <= '0;
      conv_vec_q    <= '0;
      pool_vec_q    <= '0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      err_layer_q   <= '0;
      cycle_count_q <= '0;
      wd_q          <= '0;
    end else begin
      state_q       <= state_d;
      layer_idx_q   <= layer_idx_d;
      conv_vec_q    <= conv_vec_d;
      pool_vec_q    <= pool_vec_d;
      done_q        <= done_d;
      error_q       <= error_d;
      err_layer_q   <= err_layer_d;
      cycle_count_q <= cycle_count_d;
      wd_q          <= wd_d;
    end
  end

  assign conv_start    = (state_q == S_CONV_GO);
  assign pool_start    = (state_q == S_POOL_GO);
  assign busy          = busy_w;
  assign layer_idx     = layer_idx_q;
  assign conv_done_vec = conv_vec_q;
  assign pool_done_vec = pool_vec_q;
  assign done          = done_q;
  assign error         = error_q;
  assign err_layer     = err_layer_q;
  assign cycle_count   = cycle_count_q;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// tb/tb_cnn_layer_sequencer.sv - scoreboard bench for cnn_layer_sequencer
`timescale 1ns/1ps
module tb_cnn_layer_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, abort, conv_done, pool_done;
  logic start_a, start_b, start_c;

  logic a_cs, a_ps, a_busy, a_done, a_error;
  logic [1:0] a_layer, a_cvec, a_pvec, a_elayer;
  logic [31:0] a_cc;
  logic b_cs, b_ps, b_busy, b_done, b_error;
  logic [1:0] b_layer, b_cvec, b_pvec, b_elayer;
  logic [31:0] b_cc;
  logic c_cs, c_ps, c_busy, c_done, c_error;
  logic [1:0] c_layer, c_elayer;
  logic [3:0] c_cvec, c_pvec;
  logic [31:0] c_cc;

  cnn_layer_sequencer #(.NUM_LAYERS(2), .IDX_W(2), .POOL_EN(2'b11), .TIMEOUT_W(16),
                        .TIMEOUT_CYCLES(8), .CYC_W(32)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort),
    .conv_start(a_cs), .conv_done(conv_done), .pool_start(a_ps), .pool_done(pool_done),
    .layer_idx(a_layer), .conv_done_vec(a_cvec), .pool_done_vec(a_pvec), .busy(a_busy),
    .done(a_done), .error(a_error), .err_layer(a_elayer), .cycle_count(a_cc));

  cnn_layer_sequencer #(.NUM_LAYERS(2), .IDX_W(2), .POOL_EN(2'b10), .TIMEOUT_W(16),
                        .TIMEOUT_CYCLES(8), .CYC_W(32)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort),
    .conv_start(b_cs), .conv_done(conv_done), .pool_start(b_ps), .pool_done(pool_done),
    .layer_idx(b_layer), .conv_done_vec(b_cvec), .pool_done_vec(b_pvec), .busy(b_busy),
    .done(b_done), .error(b_error), .err_layer(b_elayer), .cycle_count(b_cc));

  cnn_layer_sequencer #(.NUM_LAYERS(4), .IDX_W(2), .POOL_EN(4'hF), .TIMEOUT_W(16),
                        .TIMEOUT_CYCLES(32), .CYC_W(32)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .abort(abort),
    .conv_start(c_cs), .conv_done(conv_done), .pool_start(c_ps), .pool_done(pool_done),
    .layer_idx(c_layer), .conv_done_vec(c_cvec), .pool_done_vec(c_pvec), .busy(c_busy),
    .done(c_done), .error(c_error), .err_layer(c_elayer), .cycle_count(c_cc));

  int sel = 0;
  logic m_cs, m_ps, m_busy, m_done, m_error;
  int m_layer, m_cvec, m_pvec, m_elayer, m_cc;

  always_comb begin
    m_cs = a_cs; m_ps = a_ps; m_busy = a_busy; m_done = a_done; m_error = a_error;
    m_layer = int'(a_layer); m_cvec = int'(a_cvec); m_pvec = int'(a_pvec);
    m_elayer = int'(a_elayer); m_cc = int'(a_cc);
    if (sel == 1) begin
      m_cs = b_cs; m_ps = b_ps; m_busy = b_busy; m_done = b_done; m_error = b_error;
      m_layer = int'(b_layer); m_cvec = int'(b_cvec); m_pvec = int'(b_pvec);
      m_elayer = int'(b_elayer); m_cc = int'(b_cc);
    end else if (sel == 2) begin
      m_cs = c_cs; m_ps = c_ps; m_busy = c_busy; m_done = c_done; m_error = c_error;
      m_layer = int'(c_layer); m_cvec = int'(c_cvec); m_pvec = int'(c_pvec);
      m_elayer = int'(c_elayer); m_cc = int'(c_cc);
    end
  end

  typedef struct {
    int kind; int rel; int layer; int cvec; int pvec; int cc; int dn; int er; int bs;
  } ev_t;
  ev_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int base = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int expv);
    if (expv >= 0) begin
      checks++;
      if (act != expv) begin
        errors++;
        $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, expv, $time);
      end
    end
  endtask

  task automatic push(input int kind, input int rel, input int layer, input int cvec,
                      input int pvec, input int cc, input int dn, input int er, input int bs);
    ev_t e;
    e.kind = kind; e.rel = rel; e.layer = layer; e.cvec = cvec; e.pvec = pvec;
    e.cc = cc; e.dn = dn; e.er = er; e.bs = bs;
    exp_q.push_back(e);
  endtask

  task automatic start_ev(input int kind, input int rel, input int layer, input int cvec, input int pvec);
    push(kind, rel, layer, cvec, pvec, rel - 1, 0, 0, 1);
  endtask

  task automatic done_ev(input int rel, input int cvec, input int pvec, input int cc);
    push(2, rel, -1, cvec, pvec, cc, 1, 0, 0);
  endtask

  task automatic err_ev(input int rel, input int elayer, input int cvec, input int pvec, input int cc);
    push(3, rel, elayer, cvec, pvec, cc, 0, 1, 0);
  endtask

  task automatic observe(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_event kind=%0d rel=%0d expected=none", kind, cyc - base);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_cycle", cyc - base, e.rel);
      chk("layer", (kind == 3) ? m_elayer : m_layer, e.layer);
      chk("conv_done_vec", m_cvec, e.cvec);
      chk("pool_done_vec", m_pvec, e.pvec);
      chk("cycle_count", m_cc, e.cc);
      chk("done", int'(m_done), e.dn);
      chk("error", int'(m_error), e.er);
      chk("busy", int'(m_busy), e.bs);
    end
  endtask

  logic prev_done = 1'b0, prev_error = 1'b0;
  always @(negedge clk) begin
    if (m_cs || m_ps) chk("starts_exclusive", int'(m_cs && m_ps), 0);
    if (m_cs) observe(0);
    if (m_ps) observe(1);
    if (m_done && !prev_done) observe(2);
    if (m_error && !prev_error) observe(3);
    prev_done = m_done;
    prev_error = m_error;
  end

  int conv_lat[4] = '{3, 3, 3, 3};
  int pool_lat[4] = '{3, 3, 3, 3};
  bit conv_en = 1'b1;
  bit abort_on_pool = 1'b0;
  int cl_now, pl_now;

  always begin
    @(negedge clk);
    if (m_cs && conv_en) begin
      cl_now = conv_lat[m_layer];
      repeat (cl_now) @(negedge clk);
      conv_done = 1'b1;
      @(negedge clk);
      conv_done = 1'b0;
    end
  end

  always begin
    @(negedge clk);
    if (m_ps) begin
      pl_now = pool_lat[m_layer];
      repeat (pl_now) @(negedge clk);
      pool_done = 1'b1;
      if (abort_on_pool && m_layer == 1) abort = 1'b1;
      @(negedge clk);
      pool_done = 1'b0;
      abort = 1'b0;
    end
  end

  task automatic run_start();
    @(negedge clk);
    base = cyc;
    start_a = (sel == 0); start_b = (sel == 1); start_c = (sel == 2);
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("events_pending", exp_q.size(), 0);
    exp_q.delete();
    repeat (4) @(negedge clk);
  endtask

  task automatic check_a_zero(input string tag);
    chk({tag, "_conv_start"}, int'(a_cs), 0);
    chk({tag, "_pool_start"}, int'(a_ps), 0);
    chk({tag, "_layer_idx"}, int'(a_layer), 0);
    chk({tag, "_vecs"}, int'({a_cvec, a_pvec}), 0);
    chk({tag, "_busy"}, int'(a_busy), 0);
    chk({tag, "_done"}, int'(a_done), 0);
    chk({tag, "_error"}, int'(a_error), 0);
    chk({tag, "_err_layer"}, int'(a_elayer), 0);
    chk({tag, "_cycle_count"}, int'(a_cc), 0);
  endtask

  task automatic push_two_layer_full();
    start_ev(0, 1, 0, 0, 0);
    start_ev(1, 5, 0, 1, 0);
    start_ev(0, 10, 1, 1, 1);
    start_ev(1, 14, 1, 3, 1);
    done_ev(20, 3, 3, 19);
  endtask

  int t, ps;

  initial begin
    rst = 1'b0; abort = 1'b0; conv_done = 1'b0; pool_done = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    #3;
    check_a_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    push_two_layer_full();
    run_start();
    wait_drain(60);

    conv_en = 1'b0;
    start_ev(0, 1, 0, 0, 0);
    err_ev(10, 0, 0, 0, 9);
    run_start();
    wait_drain(60);
    conv_en = 1'b1;

    push_two_layer_full();
    run_start();
    wait_drain(60);

    abort_on_pool = 1'b1;
    start_ev(0, 1, 0, 0, 0);
    start_ev(1, 5, 0, 1, 0);
    start_ev(0, 10, 1, 1, 1);
    start_ev(1, 14, 1, 3, 1);
    err_ev(18, 1, 3, 1, 17);
    run_start();
    repeat (2) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (8) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_drain(60);
    abort_on_pool = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_in_error_err_layer", int'(a_elayer), 1);

    start_ev(0, 1, 0, 0, 0);
    start_ev(1, 5, 0, 1, 0);
    start_ev(0, 10, 1, 1, 1);
    run_start();
    repeat (10) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_a_zero("midrun_reset");
    chk("events_before_reset", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    chk("reset_held_busy", int'(a_busy), 0);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    push_two_layer_full();
    run_start();
    wait_drain(60);

    sel = 1;
    @(negedge clk);
    start_ev(0, 1, 0, 0, 0);
    start_ev(0, 6, 1, 1, 0);
    start_ev(1, 10, 1, 3, 0);
    done_ev(16, 3, 2, 15);
    run_start();
    wait_drain(60);

    sel = 2;
    @(negedge clk);
    t = 1;
    for (int i = 0; i < 4; i++) begin
      conv_lat[i] = int'($urandom_range(1, 20));
      pool_lat[i] = int'($urandom_range(1, 20));
      start_ev(0, t, i, (1 << i) - 1, (1 << i) - 1);
      ps = t + conv_lat[i] + 1;
      start_ev(1, ps, i, (1 << (i + 1)) - 1, (1 << i) - 1);
      t = ps + pool_lat[i] + 2;
    end
    done_ev(t + 1, 15, 15, t);
    run_start();
    wait_drain(400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
